// File: rtl/a2d_pkg.sv
// Shared types and helpers for the A2D round-robin sequencer.
package a2d_pkg;

    // A2D channel numbers
    localparam logic [2:0] CH_LFT  = 3'd0;
    localparam logic [2:0] CH_RGHT = 3'd4;
    localparam logic [2:0] CH_BATT = 3'd5;

    // Frame sent to clock the conversion result back out
    localparam logic [15:0] RD_FRAME = 16'h0000;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StWaitCmd,
        StGap1,
        StRd,
        StWaitRd,
        StGap2
    } a2d_state_t;

    typedef enum logic [1:0] {
        ChLft,
        ChRght,
        ChBatt
    } ch_sel_t;

    // Channel-select frame: {2'b00, channel, 11'h000}
    function automatic logic [15:0] a2d_cmd(input ch_sel_t ch);
        logic [2:0] num;
        case (ch)
            ChLft:   num = CH_LFT;
            ChRght:  num = CH_RGHT;
            ChBatt:  num = CH_BATT;
            default: num = CH_LFT;
        endcase
        return {2'b00, num, 11'h000};
    endfunction

endpackage

// File: rtl/a2d_round_robin_avg.sv
// Two-sample averager for one load-cell channel. The first sample after
// reset is stored raw; later samples store (prev + new) >> 1 with truncation.
// Only compiled when A2D_RR_AVG_EN is defined, since only that build uses it.
`ifdef A2D_RR_AVG_EN
module a2d_avg (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [11:0] sample,
    output logic [11:0] avg
);

    logic [11:0] avg_q;
    logic        primed_q;
    logic [12:0] sum;

    assign sum = {1'b0, avg_q} + {1'b0, sample};
    assign avg = avg_q;

    // Store raw on the first sample, averaged afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            avg_q    <= '0;
            primed_q <= 1'b0;
        end else if (load) begin
            avg_q    <= primed_q ? sum[12:1] : sample;
            primed_q <= 1'b1;
        end
    end

endmodule
`endif

// File: rtl/a2d_round_robin.sv
// Round-robin sequencer for the shared A2D SPI master: on each request it
// converts left load cell, right load cell and battery in that order, two SPI
// frames per channel (channel select, then read-back).
// Optional feature: define A2D_RR_AVG_EN to average lft_ld/rght_ld over two
// samples (a2d_avg); default build stores raw results.
module a2d_round_robin
    import a2d_pkg::*;
#(
    parameter int unsigned GAP_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nxt,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        busy,
    output logic        round_done
);

    localparam logic [3:0] GapLoad = 4'(GAP_CYC - 1);

    a2d_state_t  state_q, state_d;
    ch_sel_t     ch_q, ch_d;
    logic        pending_q, pending_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [15:0] cmd_q, cmd_d;
    logic        round_done_q, round_done_d;
    logic        store_lft, store_rght, store_batt;
    logic        unused_rd_hi;

    // Upper result bits carry no conversion data
    assign unused_rd_hi = ^rd_data[15:12];

    // State, channel, request and frame registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            ch_q         <= ChLft;
            pending_q    <= 1'b0;
            gap_cnt_q    <= '0;
            cmd_q        <= '0;
            round_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            pending_q    <= pending_d;
            gap_cnt_q    <= gap_cnt_d;
            cmd_q        <= cmd_d;
            round_done_q <= round_done_d;
        end
    end

    // Next-state logic; cmd is loaded on entry to CMD/RD so it is valid with wrt
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        pending_d    = pending_q;
        gap_cnt_d    = gap_cnt_q;
        cmd_d        = cmd_q;
        round_done_d = 1'b0;
        store_lft    = 1'b0;
        store_rght   = 1'b0;
        store_batt   = 1'b0;

        // A request during a round is remembered once; extras are dropped
        if (state_q != StIdle && nxt) begin
            pending_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (nxt || pending_q) begin
                    state_d   = StCmd;
                    ch_d      = ChLft;
                    cmd_d     = a2d_cmd(ChLft);
                    pending_d = 1'b0;
                end
            end
            StCmd: begin
                state_d = StWaitCmd;
            end
            StWaitCmd: begin
                if (done) begin
                    state_d   = StGap1;
                    gap_cnt_d = GapLoad;
                end
            end
            StGap1: begin
                if (gap_cnt_q == 4'd0) begin
                    state_d = StRd;
                    cmd_d   = RD_FRAME;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            StRd: begin
                state_d = StWaitRd;
            end
            StWaitRd: begin
                if (done) begin
                    case (ch_q)
                        ChLft:   store_lft  = 1'b1;
                        ChRght:  store_rght = 1'b1;
                        default: store_batt = 1'b1;
                    endcase
                    if (ch_q == ChBatt) begin
                        round_done_d = 1'b1;
                        pending_d    = 1'b0;
                        // A pending or coincident request chains straight into a new round
                        if (pending_q || nxt) begin
                            state_d = StCmd;
                            ch_d    = ChLft;
                            cmd_d   = a2d_cmd(ChLft);
                        end else begin
                            state_d = StIdle;
                            cmd_d   = '0;
                        end
                    end else begin
                        state_d   = StGap2;
                        gap_cnt_d = GapLoad;
                    end
                end
            end
            StGap2: begin
                if (gap_cnt_q == 4'd0) begin
                    state_d = StCmd;
                    ch_d    = (ch_q == ChLft) ? ChRght : ChBatt;
                    cmd_d   = a2d_cmd((ch_q == ChLft) ? ChRght : ChBatt);
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign wrt        = (state_q == StCmd) || (state_q == StRd);
    assign busy       = (state_q != StIdle);
    assign cmd        = cmd_q;
    assign round_done = round_done_q;

`ifdef A2D_RR_AVG_EN
    a2d_avg u_avg_lft (
        .clk    (clk),
        .rst    (rst),
        .load   (store_lft),
        .sample (rd_data[11:0]),
        .avg    (lft_ld)
    );

    a2d_avg u_avg_rght (
        .clk    (clk),
        .rst    (rst),
        .load   (store_rght),
        .sample (rd_data[11:0]),
        .avg    (rght_ld)
    );
`else
    // Raw load-cell results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lft_ld  <= '0;
            rght_ld <= '0;
        end else begin
            if (store_lft)  lft_ld  <= rd_data[11:0];
            if (store_rght) rght_ld <= rd_data[11:0];
        end
    end
`endif

    // Battery result is always raw
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            batt <= '0;
        end else if (store_batt) begin
            batt <= rd_data[11:0];
        end
    end

endmodule

// File: doc/a2d_round_robin.md
# a2d_round_robin

Sequencer that owns the shared SPI master to the A2D converter and walks it through the left load cell, right load cell and battery channels once per request, producing registered 12-bit `lft_ld`, `rght_ld` and `batt` values for `steer_en` and the piezo/battery logic. Each channel conversion is two SPI transactions: a command frame that selects the channel, then a read frame that returns the result. It sits between the digital core's periodic `nxt` strobe and the SPI master, and it is the only block allowed to drive the master's `wrt`/`cmd`.

## Interface
- `CH_LFT`, 3'd0: A2D channel of the left load cell.
- `CH_RGHT`, 3'd4: A2D channel of the right load cell.
- `CH_BATT`, 3'd5: A2D channel of the battery divider.
- `GAP_CYC`, 2: idle clocks between `done` and the next `wrt`, range 1..15.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset, asynchronous and active-high.
- `nxt` in 1: one-cycle request to start a conversion round.
- `wrt` out 1: one-cycle start pulse to the SPI master.
- `cmd` out 16: frame sent with `wrt`.
- `done` in 1: one-cycle pulse from the SPI master when a frame completes.
- `rd_data` in 16: frame received from the SPI master; valid while `done` is high.
- `lft_ld`, `rght_ld`, `batt` out 12: latest conversion results.
- `busy` out 1: high while a round is in progress.
- `round_done` out 1: one-cycle pulse when a round completes.

## Operation
- The round order is fixed: LFT → RGHT → BATT.
- Each channel runs CMD → WAIT_CMD → GAP → RD → WAIT_RD → GAP.
- The CMD frame is `{2'b00, ch[2:0], 11'h000}`. The RD frame is `16'h0000`.
- The result is `rd_data[11:0]`, captured on the `done` that ends the RD frame. `rd_data[15:12]` is ignored.
- States:
  - IDLE
  - CMD: pulse `wrt`
  - WAIT_CMD
  - GAP1
  - RD: pulse `wrt`
  - WAIT_RD
  - GAP2
- Transitions:
  - IDLE → CMD on `nxt` or a pending request.
  - CMD → WAIT_CMD.
  - WAIT_CMD → GAP1 on `done`.
  - GAP1 → RD after `GAP_CYC` clocks.
  - RD → WAIT_RD.
  - WAIT_RD → GAP2 on `done`, storing the result.
  - GAP2 → CMD for the next channel after `GAP_CYC` clocks.
  - After BATT is stored the FSM goes to IDLE with no GAP2.
- `cmd` holds its value from the `wrt` cycle until the next `wrt`. It is 0 in IDLE.
- A `nxt` that arrives while `busy` sets a single `pending` flag. Further `nxt` pulses while `pending` is set are dropped.
- When a round ends with `pending` set, the FSM skips IDLE, clears `pending` and enters CMD on the next clock. In that case `busy` stays high and `round_done` still pulses.
- `done` in IDLE, CMD, RD or GAP states is ignored.
- A 4-bit down-counter, loaded with `GAP_CYC-1`, times the GAP states.

## Timing
- Reset values: every output is 0, the state is IDLE, `pending` is 0, and the gap counter is 0.
- Asserting `rst` mid-round aborts the transaction. `wrt` drops in the same instant, results keep reset values, and a stale `done` after release is ignored because the FSM is in IDLE.
- `nxt` sampled high in IDLE gives `wrt` high on the next clock. `busy` rises on that same clock.
- From `done` to the next `wrt` is exactly `GAP_CYC`+1 clocks.
- A result register updates on the clock after its `done`. `round_done` pulses on the same clock that `batt` updates.
- Minimum round length with an SPI frame of F clocks: 6·(F+1) + 5·(`GAP_CYC`+1) clocks.
- `nxt` coincident with the final `done` of a round sets `pending`, so back-to-back rounds follow.

## Configuration
- `A2D_RR_AVG_EN` defined:
  - `lft_ld` and `rght_ld` store `(prev + new) >> 1`, using a 13-bit sum and truncation.
  - The first sample after reset for each channel stores raw, tracked by a per-channel `primed` flag.
  - `batt` is always raw.
- Not defined: all three registers store the raw `rd_data[11:0]`, and no `primed` flags exist.

## Structure
- Package `a2d_pkg` holds:
  - the `a2d_state_t` enum;
  - the `ch_sel_t` enum (LFT/RGHT/BATT);
  - the `RD_FRAME` constant;
  - function `a2d_cmd(ch)` that builds the CMD frame.
- Sub-module `a2d_avg` contains the 12-bit two-sample averager with its `primed` flag. It is instantiated twice, only under `A2D_RR_AVG_EN`.

## Test plan
- Single round, raw build, `GAP_CYC`=2, SPI model replies 12'h123 / 12'h456 / 12'hABC: expect three `cmd` values 16'h0000, 16'h2000, 16'h2800, then final `lft_ld`=12'h123, `rght_ld`=12'h456, `batt`=12'hABC, and one `round_done` pulse.
- Gap check: from each `done` to the next `wrt`, measure exactly 3 clocks with `GAP_CYC`=2, and 16 clocks with `GAP_CYC`=15.
- Two `nxt` pulses during a round: exactly one extra round runs back-to-back, `busy` never drops between the rounds, and two `round_done` pulses occur in total.
- Assert `rst` during WAIT_RD of RGHT, then release and inject a stray `done`: outputs stay 0, no `wrt` occurs, and the next `nxt` starts from LFT.
- `A2D_RR_AVG_EN` build, left readings 12'h100 then 12'h201: `lft_ld` is 12'h100, then 12'h180.
- Upper-bit masking: `rd_data`=16'hF7FF on `batt` gives `batt`=12'h7FF.
